// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register family: occupancy
// states of the skid-buffered stage, the bubble encoding and the payload
// widths used between each pair of pipeline stages.
package pipe_pkg;

  // Occupancy of a skid-buffered stage: nothing held, main only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // RV32I canonical NOP (addi x0, x0, 0); a natural bubble for the IF/ID stage.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] BUBBLE    = NOP_INSTR;

  // Payload widths packed by each upstream stage.
  localparam int unsigned XLEN     = 32;
  localparam int unsigned IF_ID_W  = 2 * XLEN;
  localparam int unsigned ID_EX_W  = 3 * XLEN + 5 + 16;
  localparam int unsigned EX_MEM_W = 2 * XLEN + 5 + 8;
  localparam int unsigned MEM_WB_W = XLEN + 5 + 2;

  // Width of the optional performance counters.
  localparam int unsigned PERF_CNT_W = 32;

  // Number of payload entries held in a given occupancy state.
  function automatic logic [1:0] entry_count(input state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_ONE:  n = 2'd1;
      ST_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stall/flush statistics. It sticks at its
// all-ones value instead of wrapping, and only clr returns it to zero.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PERF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Advance by one on inc unless already at the all-ones ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Synchronous clear has priority over counting.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready back-pressure and flush.
// SKID=1 holds up to two entries so in_ready can come straight from a flop;
// SKID=0 holds one entry and in_ready is combinational from out_ready.
// Optional statistics counters (stall_cnt, flush_cnt) exist only when the
// macro PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned  DATA_W      = 32,
  parameter bit           SKID        = 1'b1,
  parameter logic [127:0] BUBBLE_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // Bubble value fitted to the payload width (truncated or zero-extended).
  localparam logic [DATA_W-1:0] BUBBLE_W = DATA_W'(BUBBLE_DATA);

  generate
    if (SKID) begin : g_skid

      state_e            state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              in_ready_q, in_ready_d;
      logic              accept;
      logic              pop;

      // Next-state logic: flush empties everything; otherwise the entries
      // move as a two-deep FIFO where the skid entry always drains into main.
      always_comb begin
        accept     = in_valid & in_ready_q;
        pop        = (state_q != ST_EMPTY) & out_ready;
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_W;
          skid_d  = BUBBLE_W;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_d = ST_ONE;
                main_d  = in_data;
              end
            end
            ST_ONE: begin
              if (accept && pop) begin
                main_d = in_data;
              end else if (accept) begin
                state_d = ST_FULL;
                skid_d  = in_data;
              end else if (pop) begin
                state_d = ST_EMPTY;
                main_d  = BUBBLE_W;
              end
            end
            ST_FULL: begin
              if (pop) begin
                state_d = ST_ONE;
                main_d  = skid_q;
                skid_d  = BUBBLE_W;
              end
            end
            default: begin
              state_d = ST_EMPTY;
              main_d  = BUBBLE_W;
              skid_d  = BUBBLE_W;
            end
          endcase
        end
        in_ready_d = (state_d != ST_FULL);
      end

      // State, payload and in_ready registers with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= ST_EMPTY;
          main_q     <= BUBBLE_W;
          skid_q     <= BUBBLE_W;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (entry_count(state_q) != 2'd0);
      assign out_data  = main_q;

    end else begin : g_single

      logic              valid_q, valid_d;
      logic [DATA_W-1:0] data_q, data_d;
      logic              ready_c;
      logic              accept;
      logic              pop;

      // Single-entry register: accept overwrites, a lone pop leaves a bubble.
      always_comb begin
        ready_c = out_ready | ~valid_q;
        accept  = in_valid & ready_c;
        pop     = valid_q & out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
          valid_d = 1'b0;
          data_d  = BUBBLE_W;
        end else if (accept) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end else if (pop) begin
          valid_d = 1'b0;
          data_d  = BUBBLE_W;
        end
      end

      // Valid flag and payload registers with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= BUBBLE_W;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign in_ready  = ready_c;
      assign out_valid = valid_q;
      assign out_data  = data_q;

    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid & ~out_ready;
  assign flush_inc = flush & out_valid;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`endif

endmodule
